// File: rtl/key_entry_ctrl_pkg.sv
// Shared PS/2 set-2 scancode constants, digit tables and FSM encoding
// for the key entry controller.
package key_entry_ctrl_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   // Index is the digit value 0..9.
   localparam logic [7:0] SC_MAIN_DIGIT [10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] SC_KP_DIGIT [10] = '{
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXT   = 2'd1,
      ST_BREAK = 2'd2
   } kstate_t;

endpackage

// File: rtl/key_entry_ctrl_key_decode.sv
// Combinational classifier: maps one scancode byte to its key meaning.
// E0/F0 prefixes decode as no key; the caller handles them in its FSM.
module key_decode
   import key_entry_ctrl_pkg::*;
(
   input  logic [7:0] scan_code,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_enter,
   output logic       is_bksp,
   output logic       is_esc
);

   always_comb begin
      is_digit = 1'b0;
      digit    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (scan_code == SC_MAIN_DIGIT[i] || scan_code == SC_KP_DIGIT[i]) begin
            is_digit = 1'b1;
            digit    = 4'(i);
         end
      end
      is_enter = (scan_code == SC_ENTER);
      is_bksp  = (scan_code == SC_BKSP);
      is_esc   = (scan_code == SC_ESC);
   end

endmodule

// File: rtl/key_entry_ctrl.sv
// PS/2 numeric entry: builds a BCD buffer from digit keys, with backspace,
// escape and enter-to-commit. All outputs registered, one cycle after the byte.
module key_entry_ctrl
   import key_entry_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            scan_code,
   input  logic                  scan_valid,
   output logic [4*DIGITS-1:0]   number,
   output logic [DIGITS-1:0]     digit_en,
   output logic [4*DIGITS-1:0]   committed,
   output logic                  commit,
   output logic                  err
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);

   kstate_t              state_q, state_d;
   logic [4*DIGITS-1:0]  number_q, number_d;
   logic [4*DIGITS-1:0]  committed_q, committed_d;
   logic [CW-1:0]        count_q, count_d;
   logic [DIGITS-1:0]    digit_en_q, digit_en_d;
   logic                 commit_q, commit_d;
   logic                 err_q, err_d;

   logic       is_digit, is_enter, is_bksp, is_esc;
   logic [3:0] digit;

   key_decode u_key_decode (
      .scan_code (scan_code),
      .is_digit  (is_digit),
      .digit     (digit),
      .is_enter  (is_enter),
      .is_bksp   (is_bksp),
      .is_esc    (is_esc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         number_q    <= '0;
         committed_q <= '0;
         count_q     <= '0;
         digit_en_q  <= '0;
         commit_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         number_q    <= number_d;
         committed_q <= committed_d;
         count_q     <= count_d;
         digit_en_q  <= digit_en_d;
         commit_q    <= commit_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_EXT)        state_d = ST_EXT;
               else if (scan_code == SC_BREAK) state_d = ST_BREAK;
            end
            ST_EXT:  state_d = (scan_code == SC_BREAK) ? ST_BREAK : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Plain make codes act only in IDLE; Enter is also accepted after an E0 prefix.
   logic in_idle, do_enter;
   assign in_idle  = scan_valid && (state_q == ST_IDLE);
   assign do_enter = scan_valid && is_enter && (state_q == ST_IDLE || state_q == ST_EXT);

   always_comb begin
      number_d    = number_q;
      count_d     = count_q;
      committed_d = committed_q;
      commit_d    = 1'b0;
      err_d       = 1'b0;
      if (do_enter) begin
         committed_d = number_q;
         commit_d    = 1'b1;
         number_d    = '0;
         count_d     = '0;
      end else if (in_idle && is_digit) begin
         if (count_q == FULL) begin
            err_d = 1'b1;
         end else begin
            number_d      = number_q << 4;
            number_d[3:0] = digit;
            count_d       = count_q + 1'b1;
         end
      end else if (in_idle && is_bksp) begin
         if (count_q != '0) begin
            number_d = number_q >> 4;
            count_d  = count_q - 1'b1;
         end
      end else if (in_idle && is_esc) begin
         number_d = '0;
         count_d  = '0;
      end
      for (int i = 0; i < DIGITS; i++) begin
         digit_en_d[i] = (i < int'(count_d));
      end
   end

   assign number    = number_q;
   assign digit_en  = digit_en_q;
   assign committed = committed_q;
   assign commit    = commit_q;
   assign err       = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: hand-computed expectations after each byte.
module tb_key_entry_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  scan_code = 8'h00;
   logic        scan_valid = 1'b0;
   logic [15:0] number;
   logic [3:0]  digit_en;
   logic [15:0] committed;
   logic        commit;
   logic        err;

   int total = 0;
   int bad = 0;
   int err_seen;

   always #5 clk = ~clk;

   key_entry_ctrl #(.DIGITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .number     (number),
      .digit_en   (digit_en),
      .committed  (committed),
      .commit     (commit),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One byte strobe; returns #1 after the edge that consumes it.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scan_code  = b;
      scan_valid = 1'b1;
      @(posedge clk);
      #1;
      scan_valid = 1'b0;
      if (err) err_seen++;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_number", 32'(number), 32'h0);
      chk("rst_digit_en", 32'(digit_en), 32'h0);
      chk("rst_committed", 32'(committed), 32'h0);
      chk("rst_commit", 32'(commit), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Three digits then Enter
      send(8'h16); send(8'h1E); send(8'h26);
      chk("d3_number", 32'(number), 32'h0123);
      chk("d3_digit_en", 32'(digit_en), 32'h7);
      send(8'h5A);
      chk("ent_committed", 32'(committed), 32'h0123);
      chk("ent_commit", 32'(commit), 32'h1);
      chk("ent_number", 32'(number), 32'h0);
      chk("ent_digit_en", 32'(digit_en), 32'h0);
      idle_cycle();
      chk("ent_commit_drop", 32'(commit), 32'h0);
      chk("ent_committed_hold", 32'(committed), 32'h0123);

      // Break byte discarded
      send(8'h16); send(8'hF0); send(8'h16); send(8'h1E);
      chk("brk_number", 32'(number), 32'h0012);
      chk("brk_digit_en", 32'(digit_en), 32'h3);
      send(8'h76);
      chk("esc_number", 32'(number), 32'h0);
      chk("esc_digit_en", 32'(digit_en), 32'h0);
      chk("esc_committed", 32'(committed), 32'h0123);

      // Overflow on fifth digit
      err_seen = 0;
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      chk("full_err_low", 32'(err), 32'h0);
      send(8'h2E);
      chk("ovf_err", 32'(err), 32'h1);
      chk("ovf_number", 32'(number), 32'h1234);
      chk("ovf_digit_en", 32'(digit_en), 32'hF);
      idle_cycle();
      chk("ovf_err_drop", 32'(err), 32'h0);
      chk("ovf_err_count", 32'(err_seen), 32'h1);
      send(8'h66);
      chk("bk_full_number", 32'(number), 32'h0123);
      chk("bk_full_digit_en", 32'(digit_en), 32'h7);
      send(8'h76);

      // Backspace to empty and beyond
      send(8'h69);
      chk("kp1_number", 32'(number), 32'h1);
      chk("kp1_digit_en", 32'(digit_en), 32'h1);
      send(8'h66);
      chk("bk1_number", 32'(number), 32'h0);
      chk("bk1_digit_en", 32'(digit_en), 32'h0);
      send(8'h66);
      chk("bk2_number", 32'(number), 32'h0);
      chk("bk2_digit_en", 32'(digit_en), 32'h0);
      chk("bk2_err", 32'(err), 32'h0);

      // Extended codes: E0 6B ignored, E0 5A commits
      send(8'h7D);
      send(8'hE0); send(8'h6B);
      chk("ext_ign_number", 32'(number), 32'h9);
      send(8'hE0);
      chk("ext_prefix_commit", 32'(commit), 32'h0);
      send(8'h5A);
      chk("ext_ent_commit", 32'(commit), 32'h1);
      chk("ext_ent_committed", 32'(committed), 32'h9);
      chk("ext_ent_number", 32'(number), 32'h0);

      // Enter with empty buffer commits zero
      send(8'h5A);
      chk("empty_commit", 32'(commit), 32'h1);
      chk("empty_committed", 32'(committed), 32'h0);

      // Released Enter (E0 F0 5A) must not commit
      send(8'h45);
      send(8'hE0); send(8'hF0); send(8'h5A);
      chk("rel_ent_commit", 32'(commit), 32'h0);
      chk("rel_ent_number", 32'(number), 32'h0);
      chk("rel_ent_digit_en", 32'(digit_en), 32'h1);
      send(8'h76);

      // Reset abandons a pending E0 prefix
      send(8'h16); send(8'hE0);
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("arst_number", 32'(number), 32'h0);
      chk("arst_digit_en", 32'(digit_en), 32'h0);
      chk("arst_committed", 32'(committed), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      send(8'h1E);
      chk("post_rst_number", 32'(number), 32'h0002);
      send(8'h26);
      chk("post_rst_idle", 32'(number), 32'h0023);
      chk("post_rst_digit_en", 32'(digit_en), 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 SHALL have parameter: DIGITS, 4, number of BCD digits in the entry buffer (1..8).
REQ-002 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: scan_code  input  8  PS/2 set-2 byte from the keyboard receiver.
REQ-005 SHALL have port: scan_valid  input  1  one-cycle strobe; scan_code is valid when high.
REQ-006 SHALL have port: number  output  4*DIGITS  live entry buffer, BCD, least significant digit in [3:0].
REQ-007 SHALL have port: digit_en  output  DIGITS  bit i high when digit i holds an entered value (display blanking).
REQ-008 SHALL have port: committed  output  4*DIGITS  value latched at the last Enter.
REQ-009 SHALL have port: commit  output  1  one-cycle pulse when committed updates.
REQ-010 SHALL have port: err  output  1  one-cycle pulse when a digit is rejected because the buffer is full.

Function
REQ-011 SHALL act only on cycles with scan_valid high; with scan_valid low, all state holds and commit/err are low.
REQ-012 SHALL implement FSM states IDLE, EXT (after E0), and BREAK (after F0).
REQ-013 IDLE: E0 -> EXT; F0 -> BREAK; any other byte is decoded as a make code and the state stays IDLE.
REQ-014 EXT: F0 -> BREAK; 5A -> Enter action, then IDLE; any other byte is ignored, then IDLE.
REQ-015 BREAK: the next byte, whatever its value, is discarded, then IDLE.
REQ-016 Digit make codes SHALL be 45,16,1E,26,25,2E,36,3D,3E,46 (0..9) and keypad 70,69,72,7A,6B,73,74,6C,75,7D (0..9).
REQ-017 Digit with count<DIGITS: number <= {number shifted left 4, d}; count increments by 1.
REQ-018 Digit with count==DIGITS: number and count unchanged; err pulses.
REQ-019 Backspace (66): if count>0, number shifts right 4 with zero fill and count decrements by 1; if count==0, no action.
REQ-020 Escape (76): number and count clear to 0.
REQ-021 Enter (5A, or E0 5A): committed <= number, commit pulses, then number and count clear; this also applies when count==0 (commits 0).
REQ-022 All other make codes SHALL be ignored.
REQ-023 digit_en[i] = (i < count), registered together with count.
REQ-024 All outputs SHALL be registered; the effect of a byte is visible on the cycle after its scan_valid (latency 1).
REQ-025 count SHALL be ceil(log2(DIGITS+1)) bits wide and SHALL never exceed DIGITS.

Reset
REQ-026 reset low SHALL asynchronously force state=IDLE, number=0, count=0, digit_en=0, committed=0, commit=0, err=0.
REQ-027 reset asserted during a prefix sequence SHALL abandon the sequence; the first byte after release is treated in IDLE.

Structure
REQ-028 A shared package SHALL hold the scancode constants (E0, F0, 5A, 66, 76, digit tables) and the FSM state encoding.
REQ-029 A combinational sub-module key_decode SHALL map scan_code to {is_digit, digit value, is_enter, is_bksp, is_esc}.

Verification
REQ-030 Bytes 16,1E,26 -> number=0x0123, digit_en=4'b0111; then 5A -> committed=0x0123, commit pulse, number=0, digit_en=0.
REQ-031 Bytes 16,F0,16,1E -> number=0x0012 (the break byte is discarded, not entered).
REQ-032 Five digits 16,1E,26,25,2E -> number=0x1234, err pulses exactly once, on the fifth digit.
REQ-033 Bytes 69,66,66 -> number=0 and count=0 after the second Backspace; the extra Backspace causes no error.
REQ-034 Bytes E0,6B -> ignored (number unchanged); E0,5A -> commit pulse.
REQ-035 Bytes 16,E0 followed by reset low, then 1E -> number=0x0002, state IDLE.
